step_pulse_sequencer: RTL and testbench

//   Sits between the gearbox regulator and the stepper driver pins.

---
 rtl/gearbox_pkg.sv | 28 ++
 rtl/step_pulse_sequencer_phase_timer.sv | 36 +++
 rtl/step_pulse_sequencer.sv | 172 +++++++++++++++++
 tb/tb_step_pulse_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : gearbox_pkg                                                   |
// | Description : Shared constants for the step/dir pulse sequencer: FSM state  |
// |               encodings, default phase tick counts and the pending-counter  |
// |               saturation bound.                                             |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package gearbox_pkg;

    // Sequencer FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Default driver timing, in clk cycles
    localparam int c_step_pulse_ticks = 120;
    localparam int c_step_gap_ticks   = 120;
    localparam int c_dir_setup_ticks  = 60;

    // Largest magnitude the symmetric signed pending counter may hold
    function automatic int pend_sat_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_pulse_sequencer_phase_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : phase_timer                                                   |
// | Description : Loadable down-counter shared by the SETUP, PULSE and GAP      |
// |               phases. Counts down to zero and holds there until reloaded.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module phase_timer
    import gearbox_pkg::*;
#(
    parameter int TIMER_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] load_val,
    output logic                  zero
);

    logic [TIMER_BITS-1:0] r_count;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/step_pulse_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : step_pulse_sequencer                                          |
// | Description : Accumulates signed step requests in a saturating pending      |
// |               counter and drains it as step/dir pulses honouring dir setup, |
// |               pulse width and minimum gap timing of the stepper driver.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module step_pulse_sequencer
    import gearbox_pkg::*;
#(
    parameter int PEND_BITS        = 16,
    parameter int TIMER_BITS       = 16,
    parameter int STEP_PULSE_TICKS = c_step_pulse_ticks,
    parameter int STEP_GAP_TICKS   = c_step_gap_ticks,
    parameter int DIR_SETUP_TICKS  = c_dir_setup_ticks
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        req_step,
    input  logic                        req_up,
    output logic                        step_pulse,
    output logic                        dir,
    output logic                        busy,
    output logic signed [PEND_BITS-1:0] pending,
    output logic                        overflow
);

    localparam logic [TIMER_BITS-1:0] c_pulse_load = TIMER_BITS'(STEP_PULSE_TICKS - 1);
    localparam logic [TIMER_BITS-1:0] c_gap_load   = TIMER_BITS'(STEP_GAP_TICKS - 1);
    localparam logic [TIMER_BITS-1:0] c_setup_load = TIMER_BITS'(DIR_SETUP_TICKS - 1);

    // Arithmetic runs one bit wider so out-of-range sums are visible before truncation
    localparam logic signed [PEND_BITS:0] c_pend_max = (PEND_BITS + 1)'(pend_sat_max(PEND_BITS));
    localparam logic signed [PEND_BITS:0] c_pend_min = -c_pend_max;
    localparam logic signed [PEND_BITS:0] c_one      = {{PEND_BITS{1'b0}}, 1'b1};

    logic [1:0]                  r_state;
    logic                        r_step;
    logic                        r_dir;
    logic signed [PEND_BITS-1:0] r_pending;
    logic                        r_overflow;

    logic [1:0]                  w_state_nxt;
    logic                        w_step_nxt;
    logic                        w_dir_nxt;
    logic                        w_tmr_load;
    logic [TIMER_BITS-1:0]       w_tmr_val;
    logic                        w_tmr_zero;
    logic                        w_consume;
    logic                        w_pend_nz;
    logic                        w_want_up;
    logic signed [PEND_BITS:0]   w_pend_ext;
    logic signed [PEND_BITS:0]   w_req_delta;
    logic signed [PEND_BITS:0]   w_cons_delta;
    logic signed [PEND_BITS:0]   w_sum;
    logic signed [PEND_BITS:0]   w_keep;
    logic                        w_drop;

    phase_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .zero     (w_tmr_zero)
    );

    assign w_pend_nz = (r_pending != '0);
    // Only meaningful when pending is non-zero: a clear sign bit then means positive
    assign w_want_up = ~r_pending[PEND_BITS-1];

    // Next-state logic; a pulse start always reloads the timer and consumes one step
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_dir_nxt   = r_dir;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_consume   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_pend_nz) begin
                    if (r_dir == w_want_up) begin
                        w_state_nxt = PULSE;
                        w_step_nxt  = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_pulse_load;
                        w_consume   = 1'b1;
                    end else begin
                        w_dir_nxt   = w_want_up;
                        w_state_nxt = SETUP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_setup_load;
                    end
                end
            end
            SETUP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_tmr_zero) begin
                    // Pending may have changed sign or emptied while dir settled
                    if (w_pend_nz && (r_dir == w_want_up)) begin
                        w_state_nxt = PULSE;
                        w_step_nxt  = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_pulse_load;
                        w_consume   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            PULSE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = GAP;
                    w_step_nxt  = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_gap_load;
                end
            end
            GAP: begin
                if (w_tmr_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = 1'b0;
            end
        endcase
    end

    // Net pending change: request plus consume, request dropped if it would saturate
    assign w_pend_ext   = {r_pending[PEND_BITS-1], r_pending};
    assign w_req_delta  = req_step ? (req_up ? c_one : '1) : '0;
    assign w_cons_delta = w_consume ? (r_pending[PEND_BITS-1] ? c_one : '1) : '0;
    assign w_sum        = w_pend_ext + w_req_delta + w_cons_delta;
    assign w_keep       = w_pend_ext + w_cons_delta;
    assign w_drop       = (w_sum > c_pend_max) || (w_sum < c_pend_min);

    // State, driver pins and pending counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_step     <= 1'b0;
            r_dir      <= 1'b1;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_dir   <= w_dir_nxt;
            if (w_drop) begin
                r_pending  <= w_keep[PEND_BITS-1:0];
                r_overflow <= 1'b1;
            end else begin
                r_pending  <= w_sum[PEND_BITS-1:0];
            end
        end
    end

    assign step_pulse = r_step;
    assign dir        = r_dir;
    assign busy       = (r_state != IDLE);
    assign pending    = r_pending;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_step_pulse_sequencer                                       |
// | Description : Directed self-checking bench. Expected pulses (dir, pending   |
// |               after consume) are queued when requests are driven and popped |
// |               by a pin monitor on each rising step edge.                    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_step_pulse_sequencer;

    localparam int PEND_BITS = 4;
    localparam int PULSE_T   = 4;
    localparam int GAP_T     = 3;
    localparam int SETUP_T   = 2;

    typedef struct {
        logic dir;
        int   pend;
    } pulse_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        enable;
    logic                        req_step;
    logic                        req_up;
    logic                        step_pulse;
    logic                        dir;
    logic                        busy;
    logic signed [PEND_BITS-1:0] pending;
    logic                        overflow;

    int     checks = 0;
    int     errors = 0;
    pulse_t sb_q[$];

    step_pulse_sequencer #(
        .PEND_BITS        (PEND_BITS),
        .TIMER_BITS       (8),
        .STEP_PULSE_TICKS (PULSE_T),
        .STEP_GAP_TICKS   (GAP_T),
        .DIR_SETUP_TICKS  (SETUP_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_step   (req_step),
        .req_up     (req_up),
        .step_pulse (step_pulse),
        .dir        (dir),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input int p);
        pulse_t e;
        e.dir  = d;
        e.pend = p;
        sb_q.push_back(e);
    endtask

    task automatic wait_step(input logic v, input string tag);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (step_pulse === v) break;
        end
        chk(tag, step_pulse, v);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (busy === 1'b0 && sb_q.size() == 0) break;
        end
        chk(tag, busy, 1'b0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    // Pin monitor: pulse width, low gap, dir setup and scoreboard pop on each rise
    int     hi_cnt;
    int     lo_cnt;
    int     dir_age;
    logic   prev_step;
    logic   prev_dir;
    logic   seen_fall;
    pulse_t exp_p;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            hi_cnt    = 0;
            lo_cnt    = 0;
            dir_age   = 100;
            prev_step = 1'b0;
            prev_dir  = 1'b1;
            seen_fall = 1'b0;
        end else begin
            if (dir !== prev_dir) dir_age = 0;
            else if (dir_age < 1000) dir_age++;
            prev_dir = dir;
            if (step_pulse === 1'b1 && prev_step === 1'b0) begin
                if (seen_fall) chk("gap_low_min", lo_cnt >= GAP_T, 1'b1);
                chk("dir_setup_min", dir_age >= SETUP_T, 1'b1);
                chk("pulse_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    exp_p = sb_q.pop_front();
                    chk("pulse_dir", dir, exp_p.dir);
                    chk("pulse_pending", int'(pending), exp_p.pend);
                end
                hi_cnt = 1;
            end else if (step_pulse === 1'b1) begin
                hi_cnt++;
            end else if (prev_step === 1'b1) begin
                chk("pulse_width", hi_cnt, PULSE_T);
                seen_fall = 1'b1;
                lo_cnt    = 1;
            end else begin
                lo_cnt++;
            end
            prev_step = step_pulse;
        end
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        req_step = 1'b0;
        req_up   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_step", step_pulse, 1'b0);
        chk("rst_dir", dir, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", overflow, 1'b0);

        // 1: single up request, dir already matches
        enable = 1'b1;
        @(posedge clk); #1;
        req_step = 1'b1; req_up = 1'b1;
        push(1'b1, 0);
        @(negedge clk);
        chk("t1_pend_before", int'(pending), 0);
        @(posedge clk); #1;
        req_step = 1'b0;
        @(negedge clk);
        chk("t1_pend_one", int'(pending), 1);
        chk("t1_step_not_yet", step_pulse, 1'b0);
        @(negedge clk);
        chk("t1_step_rise", step_pulse, 1'b1);
        chk("t1_pend_consumed", int'(pending), 0);
        chk("t1_busy_pulse", busy, 1'b1);
        chk("t1_dir", dir, 1'b1);
        wait_step(1'b0, "t1_fall");
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_gap_end", busy, 1'b1);
        @(negedge clk);
        chk("t1_busy_idle", busy, 1'b0);

        // 2: three back-to-back up requests held off, then drained
        @(posedge clk); #1;
        enable = 1'b0; req_step = 1'b1; req_up = 1'b1;
        push(1'b1, 2); push(1'b1, 1); push(1'b1, 0);
        repeat (3) @(posedge clk);
        #1 req_step = 1'b0;
        @(negedge clk);
        chk("t2_pend_three", int'(pending), 3);
        chk("t2_no_busy_disabled", busy, 1'b0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_idle(200, "t2_done");
        chk("t2_pend_zero", int'(pending), 0);

        // 3: down request forces a dir change and setup delay
        @(posedge clk); #1;
        req_step = 1'b1; req_up = 1'b0;
        push(1'b0, 0);
        @(posedge clk); #1;
        req_step = 1'b0;
        @(negedge clk);
        chk("t3_pend_neg", int'(pending), -1);
        chk("t3_dir_before", dir, 1'b1);
        @(negedge clk);
        chk("t3_dir_fell", dir, 1'b0);
        chk("t3_setup_step0", step_pulse, 1'b0);
        chk("t3_setup_busy", busy, 1'b1);
        @(negedge clk);
        chk("t3_setup_step1", step_pulse, 1'b0);
        @(negedge clk);
        chk("t3_step_rise", step_pulse, 1'b1);
        chk("t3_pend_consumed", int'(pending), 0);
        wait_idle(100, "t3_done");
        chk("t3_dir_held", dir, 1'b0);

        // 4: saturation with enable low, then drain of seven pulses
        @(posedge clk); #1;
        enable = 1'b0; req_step = 1'b1; req_up = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 9) req_step = 1'b0;
            @(negedge clk);
            chk("t4_pend_sat", int'(pending), (k > 7) ? 7 : k);
            chk("t4_overflow", overflow, (k > 7) ? 1'b1 : 1'b0);
        end
        chk("t4_no_pulse", step_pulse, 1'b0);
        for (int p = 6; p >= 0; p--) push(1'b1, p);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_idle(400, "t4_done");
        chk("t4_overflow_sticky", overflow, 1'b1);
        chk("t4_pend_zero", int'(pending), 0);
        chk("t4_dir_up", dir, 1'b1);

        // 5: reset during the second high cycle of a down pulse
        @(posedge clk); #1;
        enable = 1'b0; req_step = 1'b1; req_up = 1'b0;
        repeat (2) @(posedge clk);
        #1 req_step = 1'b0;
        enable = 1'b1;
        push(1'b0, -1);
        wait_step(1'b1, "t5_rise");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_second_high", step_pulse, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_step_low", step_pulse, 1'b0);
        chk("t5_pend_zero", int'(pending), 0);
        chk("t5_busy_low", busy, 1'b0);
        chk("t5_dir_up", dir, 1'b1);
        chk("t5_overflow_clr", overflow, 1'b0);
        repeat (10) @(negedge clk);
        chk("t5_stays_idle", busy, 1'b0);
        chk("t5_sb_empty", sb_q.size(), 0);

        // 6: +1 then -1 during GAP leaves pending unchanged
        @(posedge clk); #1;
        enable = 1'b0; req_step = 1'b1; req_up = 1'b1;
        repeat (2) @(posedge clk);
        #1 req_step = 1'b0;
        enable = 1'b1;
        push(1'b1, 1); push(1'b1, 0);
        wait_step(1'b1, "t6_rise");
        wait_step(1'b0, "t6_fall");
        chk("t6_pend_gap", int'(pending), 1);
        chk("t6_busy_gap", busy, 1'b1);
        @(posedge clk); #1;
        req_step = 1'b1; req_up = 1'b1;
        @(posedge clk); #1;
        req_up = 1'b0;
        @(negedge clk);
        chk("t6_pend_plus", int'(pending), 2);
        chk("t6_still_gap", busy, 1'b1);
        @(posedge clk); #1;
        req_step = 1'b0;
        @(negedge clk);
        chk("t6_pend_back", int'(pending), 1);
        chk("t6_step_low", step_pulse, 1'b0);
        chk("t6_dir_kept", dir, 1'b1);
        wait_idle(100, "t6_done");
        chk("t6_pend_zero", int'(pending), 0);
        chk("t6_dir_final", dir, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
